// File: rtl/jk_multimode_register_pkg.sv
// Shared constants for the multimode register: operation select codes and
// the {J,K} codes understood by each per-bit JK cell.
package jk_multimode_register_pkg;

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

endpackage

// File: rtl/jk_multimode_register_if.sv
// Control/data bundle of the multimode register; the master drives the
// operation inputs and observes Q, serial_out and terminal_count.
interface jk_multimode_register_if #(
  parameter int WIDTH = 8
);

  logic             preset;
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic [WIDTH-1:0] load_value;
  logic             up_down;
  logic             serial_in;
  logic [WIDTH-1:0] Q;
  logic             serial_out;
  logic             terminal_count;

  modport master (
    output preset, enable, mode, J, K, load_value, up_down, serial_in,
    input  Q, serial_out, terminal_count
  );

  modport slave (
    input  preset, enable, mode, J, K, load_value, up_down, serial_in,
    output Q, serial_out, terminal_count
  );

endinterface

// File: rtl/jk_multimode_register_jk_cell.sv
// Combinational next-state function of a single JK bit: hold, clear,
// set or toggle according to the {j,k} pair.
module jk_cell
  import jk_multimode_register_pkg::*;
(
  input  logic i_j,
  input  logic i_k,
  input  logic i_q,
  output logic o_qNext
);

  always_comb begin
    o_qNext = i_q;
    case ({i_j, i_k})
      JK_HOLD: o_qNext = i_q;
      JK_CLR:  o_qNext = 1'b0;
      JK_SET:  o_qNext = 1'b1;
      JK_TOG:  o_qNext = ~i_q;
      default: o_qNext = i_q;
    endcase
  end

endmodule

// File: rtl/jk_multimode_register.sv
// WIDTH-bit register with per-bit JK, parallel load, modulo up/down count
// and serial shift; synchronous active-low reset beats preset beats enable.
module jk_multimode_register
  import jk_multimode_register_pkg::*;
#(
  parameter int               WIDTH        = 8,
  parameter int               MODULUS      = 2**WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [WIDTH-1:0] PRESET_VALUE = '1
) (
  input logic                    clock,
  input logic                    reset,
  jk_multimode_register_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_jkNext;
  logic [WIDTH-1:0] w_countUp;
  logic [WIDTH-1:0] w_countDown;
  logic [WIDTH-1:0] w_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_jk
      jk_cell u_cell (
        .i_j     (bus.J[gi]),
        .i_k     (bus.K[gi]),
        .i_q     (r_q[gi]),
        .o_qNext (w_jkNext[gi])
      );
    end
  endgenerate

  // Out-of-range values (after a raw LOAD) fold back into the modulus.
  assign w_countUp   = (r_q >= MAX_COUNT) ? '0 : r_q + WIDTH'(1);
  assign w_countDown = (r_q == '0 || r_q > MAX_COUNT) ? MAX_COUNT : r_q - WIDTH'(1);

  always_comb begin
    w_next = r_q;
    case (bus.mode)
      MODE_JK:    w_next = w_jkNext;
      MODE_LOAD:  w_next = bus.load_value;
      MODE_COUNT: w_next = bus.up_down ? w_countUp : w_countDown;
      MODE_SHIFT: w_next = {r_q[WIDTH-2:0], bus.serial_in};
      default:    w_next = r_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q <= RESET_VALUE;
    end else if (bus.preset) begin
      r_q <= PRESET_VALUE;
    end else if (bus.enable) begin
      r_q <= w_next;
    end
  end

  assign bus.Q          = r_q;
  assign bus.serial_out = r_q[WIDTH-1];
  assign bus.terminal_count = (bus.mode == MODE_COUNT) && bus.enable && reset && !bus.preset
                           && (bus.up_down ? (r_q >= MAX_COUNT) : (r_q == '0));

endmodule

// File: tb/tb_jk_multimode_register.sv
// Self-checking bench for jk_multimode_register (WIDTH=4, MODULUS=10):
// directed vector table, a cascade-style count run, then random vs model.
module tb_jk_multimode_register;

  localparam int W   = 4;
  localparam int MOD = 10;

  typedef struct {
    bit rst;
    bit pre;
    bit en;
    int mode;
    int j;
    int k;
    int ld;
    bit ud;
    bit si;
    int expQ;
    bit expTc;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   modelQ;

  jk_multimode_register_if #(.WIDTH(W)) busIf ();

  jk_multimode_register #(
    .WIDTH        (W),
    .MODULUS      (MOD),
    .RESET_VALUE  (4'b0000),
    .PRESET_VALUE (4'b1111)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (busIf)
  );

  always #5 clock = ~clock;

  // Reference model written from the operation rules using plain integers.
  function automatic int modelNext(int q, bit rst, bit pre, bit en, int mode,
                                   int j, int k, int ld, bit ud, bit si);
    if (!rst) return 0;
    if (pre) return 15;
    if (!en) return q;
    case (mode)
      0: return ((j & ~q) | (~k & q)) & 15;
      1: return ld & 15;
      2: if (ud) return (q >= MOD - 1) ? 0 : q + 1;
         else    return (q == 0 || q > MOD - 1) ? MOD - 1 : q - 1;
      default: return ((q * 2) + si) % 16;
    endcase
  endfunction

  function automatic bit modelTc(int q, bit rst, bit pre, bit en, int mode, bit ud);
    if (mode != 2 || !en || !rst || pre) return 1'b0;
    return ud ? (q >= MOD - 1) : (q == 0);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, checks terminal_count before the edge and
  // Q/serial_out after it.
  task automatic applyStimulus(input vec_t v, input string name);
    @(negedge clock);
    reset                = v.rst;
    busIf.preset         = v.pre;
    busIf.enable         = v.en;
    busIf.mode           = 2'(v.mode);
    busIf.J              = 4'(v.j);
    busIf.K              = 4'(v.k);
    busIf.load_value     = 4'(v.ld);
    busIf.up_down        = v.ud;
    busIf.serial_in      = v.si;
    #1;
    checkOutput({name, " tc"}, int'(busIf.terminal_count), int'(v.expTc));
    @(posedge clock);
    #1;
    checkOutput({name, " Q"}, int'(busIf.Q), v.expQ);
    checkOutput({name, " so"}, int'(busIf.serial_out), (v.expQ >> 3) & 1);
  endtask

  vec_t table_q[$];
  vec_t v;
  int   tcPulses;

  initial begin
    busIf.preset = 1'b0; busIf.enable = 1'b0; busIf.mode = 2'b00;
    busIf.J = '0; busIf.K = '0; busIf.load_value = '0;
    busIf.up_down = 1'b0; busIf.serial_in = 1'b0;

    //              rst pre en mode j   k   ld  ud si expQ tc
    table_q.push_back('{0, 1, 1, 2, 0,  0,  0,  1, 0, 0,  0});  // reset beats preset
    table_q.push_back('{1, 1, 1, 2, 0,  0,  0,  1, 0, 15, 0});  // preset
    table_q.push_back('{1, 0, 1, 1, 0,  0,  5,  0, 0, 5,  0});
    table_q.push_back('{1, 0, 0, 0, 3,  6,  0,  0, 0, 5,  0});  // JK disabled
    table_q.push_back('{1, 0, 1, 0, 3,  6,  0,  0, 0, 3,  0});  // JK hold/clr/tog/set
    table_q.push_back('{1, 0, 1, 1, 0,  0,  8,  1, 0, 8,  0});
    table_q.push_back('{1, 0, 1, 2, 0,  0,  0,  1, 0, 9,  0});
    table_q.push_back('{1, 0, 1, 2, 0,  0,  0,  1, 0, 0,  1});  // wrap up
    table_q.push_back('{1, 0, 1, 2, 0,  0,  0,  0, 0, 9,  1});  // wrap down
    table_q.push_back('{1, 0, 1, 2, 0,  0,  0,  0, 0, 8,  0});
    table_q.push_back('{1, 0, 1, 1, 0,  0,  15, 0, 0, 15, 0});
    table_q.push_back('{1, 0, 1, 2, 0,  0,  0,  1, 0, 0,  1});  // out of range up
    table_q.push_back('{1, 0, 1, 1, 0,  0,  15, 0, 0, 15, 0});
    table_q.push_back('{1, 0, 1, 2, 0,  0,  0,  0, 0, 9,  0});  // out of range down
    table_q.push_back('{1, 0, 1, 1, 0,  0,  12, 0, 0, 12, 0});
    table_q.push_back('{1, 0, 1, 2, 0,  0,  0,  1, 0, 0,  1});
    table_q.push_back('{1, 0, 1, 1, 0,  0,  11, 0, 0, 11, 0});
    table_q.push_back('{1, 0, 1, 3, 0,  0,  0,  0, 0, 6,  0});  // shift in 0
    table_q.push_back('{1, 0, 1, 3, 0,  0,  0,  0, 1, 13, 0});  // shift in 1
    table_q.push_back('{0, 1, 1, 3, 0,  0,  0,  0, 1, 0,  0});
    table_q.push_back('{1, 1, 0, 1, 0,  0,  4,  0, 0, 15, 0});  // preset ignores enable
    table_q.push_back('{1, 0, 1, 1, 0,  0,  8,  1, 0, 8,  0});
    table_q.push_back('{1, 0, 1, 2, 0,  0,  0,  1, 0, 9,  0});
    table_q.push_back('{1, 0, 1, 1, 0,  0,  3,  1, 0, 3,  0});  // COUNT->LOAD at 9
    table_q.push_back('{1, 0, 1, 1, 0,  0,  9,  1, 0, 9,  0});
    table_q.push_back('{1, 0, 0, 2, 0,  0,  0,  1, 0, 9,  0});  // tc gated by enable
    table_q.push_back('{1, 1, 1, 2, 0,  0,  0,  1, 0, 15, 0});  // tc gated by preset

    for (int i = 0; i < table_q.size(); i++) begin
      applyStimulus(table_q[i], $sformatf("vec%0d", i));
    end

    // Cascade use: counting up from 0 through one full period pulses tc once.
    v = '{0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0};
    applyStimulus(v, "cascade reset");
    tcPulses = 0;
    for (int i = 0; i < MOD; i++) begin
      @(negedge clock);
      reset = 1'b1; busIf.preset = 1'b0; busIf.enable = 1'b1;
      busIf.mode = 2'b10; busIf.up_down = 1'b1;
      #1;
      if (busIf.terminal_count) tcPulses++;
      @(posedge clock);
      #1;
      checkOutput($sformatf("cascade step%0d Q", i), int'(busIf.Q), (i + 1) % MOD);
    end
    checkOutput("cascade tc pulses", tcPulses, 1);

    modelQ = 0;
    for (int i = 0; i < 400; i++) begin
      v.rst  = (i == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
      v.pre  = ($urandom_range(0, 15) == 0);
      v.en   = ($urandom_range(0, 7) != 0);
      v.mode = $urandom_range(0, 3);
      v.j    = $urandom_range(0, 15);
      v.k    = $urandom_range(0, 15);
      v.ld   = $urandom_range(0, 15);
      v.ud   = 1'($urandom_range(0, 1));
      v.si   = 1'($urandom_range(0, 1));
      v.expTc = modelTc(modelQ, v.rst, v.pre, v.en, v.mode, v.ud);
      v.expQ  = modelNext(modelQ, v.rst, v.pre, v.en, v.mode, v.j, v.k, v.ld, v.ud, v.si);
      applyStimulus(v, $sformatf("rand%0d", i));
      modelQ = v.expQ;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_multimode_register.md
Name: jk_multimode_register

Overview:
- Parametrised successor to the single-bit JK flip-flop.
- WIDTH-bit register bank with per-bit JK update, parallel load, modulo up/down counting and serial shift, selected by a 2-bit mode input.
- Synchronous preset/clear. All state changes on the rising edge of one clock.
- Used as the general-purpose state/count element in the team's sequential datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- MODULUS, 2**WIDTH, count-mode modulus; the counter runs 0..MODULUS-1; legal range is 2..2**WIDTH.
- RESET_VALUE, 0, Q value after reset.
- PRESET_VALUE, all ones, Q value after preset.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- preset  input  1  synchronous, active-high; loads PRESET_VALUE.
- enable  input  1  when low, the mode operation does not run and Q holds.
- mode  input  2  operation select: 00 JK, 01 LOAD, 10 COUNT, 11 SHIFT.
- J  input  WIDTH  per-bit J, used in JK mode.
- K  input  WIDTH  per-bit K, used in JK mode.
- load_value  input  WIDTH  parallel load data, used in LOAD mode.
- up_down  input  1  count direction: 1 up, 0 down.
- serial_in  input  1  shift-in bit, used in SHIFT mode.
- Q  output  WIDTH  register state.
- serial_out  output  1  equals Q[WIDTH-1].
- terminal_count  output  1  combinational; flags that the next count step wraps.

Behaviour:
- Priority at each rising edge of clock:
  - reset==0 -> Q=RESET_VALUE.
  - else preset==1 -> Q=PRESET_VALUE, in any mode and regardless of enable.
  - else enable==0 -> Q holds.
  - else the mode operation below runs.
- Q is RESET_VALUE at the first edge where reset is sampled low. After reset, serial_out=RESET_VALUE[WIDTH-1]. There is no async path: reset asserted mid-cycle takes effect only at the next edge.
- JK (00), per bit i, using the J[i]/K[i] pair:
  - 00 hold.
  - 01 clear to 0.
  - 10 set to 1.
  - 11 toggle.
  - Each bit is independent of the others.
- LOAD (01): Q=load_value, raw and unchecked, even when load_value is MODULUS or greater.
- COUNT (10):
  - Up: if Q >= MODULUS-1 then Q=0, else Q=Q+1.
  - Down: if Q==0 then Q=MODULUS-1; else if Q > MODULUS-1 then Q=MODULUS-1; else Q=Q-1.
  - Arithmetic is WIDTH-bit unsigned. No overflow is visible outside the modulus rule.
- SHIFT (11): Q={Q[WIDTH-2:0], serial_in}, shifting toward the MSB. serial_out always equals Q[WIDTH-1].
- terminal_count is high only when all of the following hold:
  - mode==COUNT, enable==1, reset==1, preset==0;
  - and either up_down==1 with Q >= MODULUS-1, or up_down==0 with Q==0.
  - It is low in all other cases.
  - It is usable as the enable of a cascaded stage: no added latency, and it is asserted in the same cycle as the wrapping edge's setup.
- A change of mode or direction takes effect at the next edge. No internal state exists besides Q.
- Latency: every operation completes in 1 cycle. Q is registered; terminal_count and serial_out are driven from Q and inputs only.

Decomposition:
- Shared package:
  - Mode localparams MODE_JK=2'b00, MODE_LOAD=2'b01, MODE_COUNT=2'b10, MODE_SHIFT=2'b11.
  - JK code constants JK_HOLD/JK_CLR/JK_SET/JK_TOG.
- Sub-module jk_cell:
  - Purely combinational next-bit function of (j, k, q).
  - Instantiated WIDTH times in a generate loop for JK mode.
- Count/shift/load next-state logic and the single Q register live in the top module.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10.
- Reset priority: drive reset=0 with preset=1, enable=1, mode=COUNT -> Q=0000 at the next edge and terminal_count=0. Release reset, keep preset=1 -> Q=1111.
- JK mode: Q=0101, J=0011, K=0110, enable=1 -> Q=0011 (bit3 hold, bit2 clear, bit1 toggle, bit0 set). The same stimulus with enable=0 -> Q stays 0101.
- Count up from LOAD 8:
  - 8 -> 9 with terminal_count=1 while Q=9.
  - 9 -> 0.
  - Switch up_down=0 at Q=0: terminal_count=1, next Q=9, then 8.
- Out-of-range count:
  - LOAD 1111 then count up -> Q=0000.
  - LOAD 1111 then count down -> Q=1001.
  - LOAD 1100: terminal_count=1 while counting up.
- Shift: from Q=1011, serial_in 0 then 1 -> Q=0110 then 1101; serial_out is 1, 0, 1 across those three cycles.
- Simultaneous events:
  - reset=0 with preset=1 in SHIFT mode -> Q=0000.
  - preset=1 with enable=0 -> Q=1111.
  - Mode changed from COUNT to LOAD on the edge where Q=9 -> Q=load_value with no wrap.
